// File: rtl/dac_pkg.sv
// Shared definitions for the MCP4725 write scheduler: code width, device
// constants, scheduler state encoding and the round-robin pointer helper.
package dac_pkg;

    localparam int DAC_CODE_W = 12;

    // MCP4725 power-down select bits (PD1:PD0)
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_500K   = 2'b11;

    // 7-bit address 0x61 shifted left with the R/W bit cleared
    localparam logic [7:0] DAC_ADDR_W = 8'hC2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } sched_state_t;

    // Requester index following idx, wrapping at n
    function automatic logic [2:0] next_ptr(input logic [2:0] idx, input int unsigned n);
        return (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dac_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after
// ptr, wrapping. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       gnt_idx,
    output logic             any_req
);

    // Rotating search from ptr; requests are padded to 8 so a 3-bit index is always in range
    always_comb begin
        logic [7:0] req_pad;
        logic [3:0] pos;
        logic       found;
        req_pad = 8'(req);
        pos     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= 4'(N_REQ)) begin
                pos = pos - 4'(N_REQ);
            end
            if (!found && req_pad[pos[2:0]]) begin
                found   = 1'b1;
                gnt_idx = pos[2:0];
            end
        end
        any_req = found;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            gnt[j] = found && (gnt_idx == 3'(j));
        end
    end

endmodule

// File: rtl/dac_write_scheduler.sv
// Shares one MCP4725 write engine among N_REQ requesters: one pending code per
// requester (newest wins), round-robin grant, NACK retry, inter-write gap and
// a watchdog on the engine's done.
module dac_write_scheduler
    import dac_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MIN_GAP     = 250,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        i_clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [DAC_CODE_W*N_REQ-1:0] i_req_code,
    output logic [N_REQ-1:0]            o_pending,
    output logic [N_REQ-1:0]            o_overwrite,
    output logic                        o_wr_start,
    output logic [DAC_CODE_W-1:0]       o_wr_code,
    output logic [2:0]                  o_wr_owner,
    input  logic                        i_wr_done,
    input  logic                        i_wr_nack,
    output logic [N_REQ-1:0]            o_done,
    output logic                        o_err,
    output logic [2:0]                  o_err_owner
);

    localparam int CNT_MAX = (TIMEOUT_CYC > MIN_GAP) ? TIMEOUT_CYC : MIN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(MIN_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    sched_state_t           state;
    logic [CNT_W-1:0]       cnt;
    logic [RETRY_W-1:0]     retry;
    logic                   reissue;
    logic [2:0]             ptr;
    logic [N_REQ-1:0]       owner_oh;

    logic [N_REQ-1:0]       pending;
    logic [DAC_CODE_W-1:0]  pend_code [N_REQ];

    logic [N_REQ-1:0]       gnt_oh;
    logic [2:0]             gnt_idx;
    logic                   any_req;
    logic [N_REQ-1:0]       grant_clr;
    logic [DAC_CODE_W-1:0]  gnt_code;

    assign o_pending = pending;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) arb (
        .req     (pending),
        .ptr     (ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // Pending bit consumed by a grant this cycle
    always_comb begin
        grant_clr = '0;
        if (state == IDLE && any_req) begin
            grant_clr = gnt_oh;
        end
    end

    // Code of the granted requester
    always_comb begin
        gnt_code = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_oh[k]) begin
                gnt_code = pend_code[k];
            end
        end
    end

    // Capture new codes; a strobe in the grant cycle re-arms pending without an overwrite pulse
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            o_overwrite <= '0;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                pend_code[k] <= '0;
            end
        end else begin
            o_overwrite <= i_req_valid & pending & ~grant_clr;
            pending     <= (pending & ~grant_clr) | i_req_valid;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (i_req_valid[k]) begin
                    pend_code[k] <= i_req_code[DAC_CODE_W*k +: DAC_CODE_W];
                end
            end
        end
    end

    // Scheduler FSM: grant, start pulse, wait for done/NACK/timeout, enforced gap
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            retry       <= '0;
            reissue     <= 1'b0;
            ptr         <= '0;
            owner_oh    <= '0;
            o_wr_start  <= 1'b0;
            o_wr_code   <= '0;
            o_wr_owner  <= '0;
            o_done      <= '0;
            o_err       <= 1'b0;
            o_err_owner <= '0;
        end else begin
            o_wr_start <= 1'b0;
            o_done     <= '0;
            o_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        o_wr_code  <= gnt_code;
                        o_wr_owner <= gnt_idx;
                        owner_oh   <= gnt_oh;
                        ptr        <= next_ptr(gnt_idx, N_REQ);
                        retry      <= '0;
                        o_wr_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_wr_done) begin
                        cnt   <= '0;
                        state <= GAP;
                        if (!i_wr_nack) begin
                            o_done  <= owner_oh;
                            reissue <= 1'b0;
                        end else if (retry < RETRY_LIMIT) begin
                            retry   <= retry + 1'b1;
                            reissue <= 1'b1;
                        end else begin
                            o_err       <= 1'b1;
                            o_err_owner <= o_wr_owner;
                            reissue     <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        o_err       <= 1'b1;
                        o_err_owner <= o_wr_owner;
                        reissue     <= 1'b0;
                        cnt         <= '0;
                        state       <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (reissue) begin
                            reissue    <= 1'b0;
                            o_wr_start <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench for dac_write_scheduler: a table of grant scenarios followed
// by hand-written overwrite, NACK-retry, timeout, collision and reset sequences.
module tb_dac_write_scheduler;

    localparam int N   = 4;
    localparam int GAP = 8;
    localparam int TMO = 100;

    logic          i_clk = 1'b0;
    logic          reset;
    logic [N-1:0]  i_req_valid;
    logic [12*N-1:0] i_req_code;
    logic [N-1:0]  o_pending;
    logic [N-1:0]  o_overwrite;
    logic          o_wr_start;
    logic [11:0]   o_wr_code;
    logic [2:0]    o_wr_owner;
    logic          i_wr_done;
    logic          i_wr_nack;
    logic [N-1:0]  o_done;
    logic          o_err;
    logic [2:0]    o_err_owner;

    dac_write_scheduler #(
        .N_REQ(N),
        .MIN_GAP(GAP),
        .MAX_RETRY(2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk       (i_clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_code  (i_req_code),
        .o_pending   (o_pending),
        .o_overwrite (o_overwrite),
        .o_wr_start  (o_wr_start),
        .o_wr_code   (o_wr_code),
        .o_wr_owner  (o_wr_owner),
        .i_wr_done   (i_wr_done),
        .i_wr_nack   (i_wr_nack),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_owner (o_err_owner)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [47:0] codes;
        int          n;
        logic [11:0] order;
    } row_t;

    row_t       rows [6];
    int         errors = 0;
    int         checks = 0;
    int         now = 0;
    int         t0, ts, td, te;
    bit         ok;
    bit         seen_err, seen_start;
    logic [2:0] owner;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
        now++;
    endtask

    task automatic wait_start(input int budget, output int t, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            nxt();
            if (o_wr_start) found = 1'b1;
        end
        t = now;
    endtask

    task automatic serve(input int delay, input logic nack);
        repeat (delay) nxt();
        i_wr_done = 1'b1;
        i_wr_nack = nack;
        nxt();
        i_wr_done = 1'b0;
        i_wr_nack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", now);
        $fatal(1);
    end

    initial begin
        rows[0] = '{valid: 4'b0010, codes: {12'h000, 12'h000, 12'h7FF, 12'h000}, n: 1,
                    order: {3'd0, 3'd0, 3'd0, 3'd1}};
        rows[1] = '{valid: 4'b1111, codes: {12'h103, 12'h102, 12'h101, 12'h100}, n: 4,
                    order: {3'd1, 3'd0, 3'd3, 3'd2}};
        rows[2] = '{valid: 4'b1000, codes: {12'h333, 12'h000, 12'h000, 12'h000}, n: 1,
                    order: {3'd0, 3'd0, 3'd0, 3'd3}};
        rows[3] = '{valid: 4'b1111, codes: {12'h203, 12'h202, 12'h201, 12'h200}, n: 4,
                    order: {3'd3, 3'd2, 3'd1, 3'd0}};
        rows[4] = '{valid: 4'b0101, codes: {12'h000, 12'h4C2, 12'h000, 12'h4C0}, n: 2,
                    order: {3'd0, 3'd0, 3'd2, 3'd0}};
        rows[5] = '{valid: 4'b0110, codes: {12'h000, 12'h562, 12'h561, 12'h000}, n: 2,
                    order: {3'd0, 3'd0, 3'd2, 3'd1}};

        reset       = 1'b1;
        i_req_valid = '0;
        i_req_code  = '0;
        i_wr_done   = 1'b0;
        i_wr_nack   = 1'b0;
        repeat (3) nxt();
        chk("rst_pending",   o_pending,   0);
        chk("rst_overwrite", o_overwrite, 0);
        chk("rst_start",     o_wr_start,  0);
        chk("rst_code",      o_wr_code,   0);
        chk("rst_owner",     o_wr_owner,  0);
        chk("rst_done",      o_done,      0);
        chk("rst_err",       {o_err, o_err_owner}, 0);
        reset = 1'b0;
        repeat (2) nxt();

        // Table: grant order, latency, codes, done pulses, gap
        for (int r = 0; r < 6; r++) begin
            i_req_valid = rows[r].valid;
            i_req_code  = rows[r].codes;
            t0 = now;
            nxt();
            i_req_valid = '0;
            for (int j = 0; j < rows[r].n; j++) begin
                owner = rows[r].order[3*j +: 3];
                wait_start(GAP + 40, ts, ok);
                chk("start_seen", ok, 1);
                if (j == 0) chk("start_latency", ts - t0, 2);
                else        chk("gap_respected", (ts - td) >= GAP, 1);
                chk("wr_owner", o_wr_owner, owner);
                chk("wr_code", o_wr_code, rows[r].codes[12*owner +: 12]);
                serve(10, 1'b0);
                td = now;
                chk("done_pulse", o_done, 4'b0001 << owner);
                chk("err_quiet", o_err, 0);
            end
            chk("pending_drained", o_pending, 0);
            repeat (GAP + 4) nxt();
        end

        // Overwrite while the engine is busy on requester 0
        i_req_valid = 4'b0001;
        i_req_code  = {12'h000, 12'h000, 12'h000, 12'h0AA};
        nxt();
        i_req_valid = '0;
        wait_start(GAP + 40, ts, ok);
        chk("ovw_start0", ok, 1);
        chk("ovw_owner0", o_wr_owner, 0);
        nxt();
        i_req_valid = 4'b0010;
        i_req_code  = {12'h000, 12'h000, 12'h111, 12'h000};
        nxt();
        chk("ovw_first_none", o_overwrite, 0);
        chk("ovw_pending1", o_pending, 4'b0010);
        i_req_code  = {12'h000, 12'h000, 12'h222, 12'h000};
        nxt();
        i_req_valid = '0;
        chk("ovw_pulse", o_overwrite, 4'b0010);
        nxt();
        chk("ovw_one_cycle", o_overwrite, 0);
        serve(6, 1'b0);
        chk("ovw_done0", o_done, 4'b0001);
        wait_start(GAP + 40, ts, ok);
        chk("ovw_start1", ok, 1);
        chk("ovw_owner1", o_wr_owner, 1);
        chk("ovw_code1", o_wr_code, 12'h222);
        serve(10, 1'b0);
        chk("ovw_done1", o_done, 4'b0010);
        repeat (GAP + 4) nxt();

        // NACK three times: two retries then error, gap after each
        i_req_valid = 4'b0100;
        i_req_code  = {12'h000, 12'hABC, 12'h000, 12'h000};
        nxt();
        i_req_valid = '0;
        for (int a = 0; a < 3; a++) begin
            wait_start(GAP + 40, ts, ok);
            chk("nack_start", ok, 1);
            if (a > 0) chk("retry_gap", ts - td, GAP);
            chk("nack_owner", o_wr_owner, 2);
            chk("nack_code", o_wr_code, 12'hABC);
            serve(5, 1'b1);
            td = now;
            chk("nack_no_done", o_done, 0);
            chk("nack_err", o_err, (a == 2) ? 1 : 0);
        end
        chk("nack_err_owner", o_err_owner, 2);
        wait_start(GAP + 30, ts, ok);
        chk("no_fourth_start", ok, 0);
        chk("nack_pending", o_pending, 0);

        // Watchdog: engine never answers
        i_req_valid = 4'b1000;
        i_req_code  = {12'h3C3, 12'h000, 12'h000, 12'h000};
        nxt();
        i_req_valid = '0;
        wait_start(GAP + 40, ts, ok);
        chk("tmo_start", ok, 1);
        chk("tmo_owner", o_wr_owner, 3);
        ok = 1'b0;
        for (int i = 0; i < TMO + 50 && !ok; i++) begin
            nxt();
            if (o_err) ok = 1'b1;
        end
        te = now;
        chk("tmo_err_seen", ok, 1);
        chk("tmo_err_cycle", te - ts, TMO + 1);
        chk("tmo_err_owner", o_err_owner, 3);
        chk("tmo_no_done", o_done, 0);
        nxt();
        chk("tmo_err_one_cycle", o_err, 0);
        i_wr_done = 1'b1;
        nxt();
        i_wr_done = 1'b0;
        nxt();
        chk("stray_done_ignored", o_done, 0);
        wait_start(GAP + 20, ts, ok);
        chk("tmo_no_restart", ok, 0);

        // Strobe in the grant cycle keeps the new code pending
        i_req_valid = 4'b0001;
        i_req_code  = {12'h000, 12'h000, 12'h000, 12'h0A1};
        nxt();
        i_req_code  = {12'h000, 12'h000, 12'h000, 12'h0B2};
        nxt();
        i_req_valid = '0;
        chk("col_start", o_wr_start, 1);
        chk("col_code", o_wr_code, 12'h0A1);
        chk("col_pending", o_pending, 4'b0001);
        chk("col_no_overwrite", o_overwrite, 0);
        serve(10, 1'b0);
        chk("col_done", o_done, 4'b0001);
        wait_start(GAP + 40, ts, ok);
        chk("col_restart", ok, 1);
        chk("col_code2", o_wr_code, 12'h0B2);

        // Reset in WAIT: pending cleared, no error, resume from IDLE with ptr 0
        nxt();
        i_req_valid = 4'b1000;
        i_req_code  = {12'h777, 12'h000, 12'h000, 12'h000};
        nxt();
        i_req_valid = '0;
        nxt();
        chk("pre_rst_pending", o_pending, 4'b1000);
        reset = 1'b1;
        nxt();
        chk("wait_rst_pending", o_pending, 0);
        chk("wait_rst_code", {o_wr_start, o_wr_code, o_wr_owner}, 0);
        chk("wait_rst_err", o_err, 0);
        reset = 1'b0;
        seen_err   = 1'b0;
        seen_start = 1'b0;
        for (int i = 0; i < TMO + GAP + 20; i++) begin
            nxt();
            if (o_err) seen_err = 1'b1;
            if (o_wr_start) seen_start = 1'b1;
        end
        chk("post_rst_no_err", seen_err, 0);
        chk("post_rst_no_start", seen_start, 0);
        i_req_valid = 4'b1010;
        i_req_code  = {12'h7A7, 12'h000, 12'h5A5, 12'h000};
        t0 = now;
        nxt();
        i_req_valid = '0;
        wait_start(GAP + 40, ts, ok);
        chk("resume_start", ok, 1);
        chk("resume_latency", ts - t0, 2);
        chk("resume_owner", o_wr_owner, 1);
        chk("resume_code", o_wr_code, 12'h5A5);
        serve(10, 1'b0);
        chk("resume_done", o_done, 4'b0010);
        wait_start(GAP + 40, ts, ok);
        chk("resume_start2", ok, 1);
        chk("resume_owner2", o_wr_owner, 3);
        chk("resume_code2", o_wr_code, 12'h7A7);
        serve(10, 1'b0);
        chk("resume_done2", o_done, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_write_scheduler.md
Name: dac_write_scheduler

Overview:
- Shares one MCP4725 I2C write engine among N_REQ requesters, each supplying 12-bit DAC codes.
- Holds one pending code per requester; a newer code replaces an unsent one.
- Grants the engine round-robin and retries writes the DAC NACKs.
- Enforces a minimum idle gap between writes and a busy watchdog. Sits between application logic and the I2C DAC write engine.

Parameters:
N_REQ, 4, number of requesters (2..8)
MIN_GAP, 250, i_clk cycles idle after each engine transaction before the next start
MAX_RETRY, 2, NACK retries per write (0 = no retry)
TIMEOUT_CYC, 50000, i_clk cycles allowed in WAIT before abort

Ports:
i_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_req_valid  in  N_REQ  per-requester write strobe, one cycle per code
i_req_code  in  12*N_REQ  code for requester k in bits [12k+11:12k]
o_pending  out  N_REQ  pending-code flag per requester
o_overwrite  out  N_REQ  one-cycle pulse: an unsent pending code was replaced
o_wr_start  out  1  one-cycle start pulse to the engine
o_wr_code  out  12  code to the engine, stable from start until done
o_wr_owner  out  3  index of the granted requester
i_wr_done  in  1  engine transaction finished (one-cycle pulse)
i_wr_nack  in  1  qualifies i_wr_done: address or data NACKed
o_done  out  N_REQ  one-cycle pulse: requester k's code was written and ACKed
o_err  out  1  one-cycle pulse: write abandoned after retries or timeout
o_err_owner  out  3  requester of the last error, held until the next error

Behaviour:
- Reset: every output is 0, all pending flags and codes are cleared, FSM is IDLE, round-robin pointer is 0 (requester 0 has highest priority first).
- Capture:
  - i_req_valid[k] stores the code into pend_code[k] and sets pending[k] on the next edge. Requesters are always accepted; there is no ready.
  - If pending[k] was already set, o_overwrite[k] pulses the same edge.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If any pending bit is set, the arbiter picks the first set bit at or after ptr, wrapping.
  - Latch o_wr_code and o_wr_owner, clear pending[g], set ptr = g+1 mod N_REQ, zero the retry count, go to ISSUE.
  - If i_req_valid[g] arrives in the grant cycle, the new code stays pending. Set wins over clear, and there is no overwrite pulse.
- ISSUE: o_wr_start=1 for exactly one cycle, then WAIT. Grant-to-start latency is 1 cycle; first valid to start is 2 cycles when the FSM is idle.
- WAIT, counting cycles:
  - i_wr_done with !i_wr_nack: pulse o_done[owner], go to GAP.
  - i_wr_done with i_wr_nack and retry < MAX_RETRY: retry++, go to GAP with a reissue flag set. GAP then returns to ISSUE with the same code, not to IDLE.
  - i_wr_done with i_wr_nack and retry == MAX_RETRY: pulse o_err, set o_err_owner, go to GAP.
  - Counter reaches TIMEOUT_CYC-1 with no done: pulse o_err, go to GAP.
  - A done arriving after timeout is ignored in all states except WAIT.
- GAP: count MIN_GAP cycles, then go to ISSUE if the reissue flag is set, else IDLE. The gap applies after every transaction, including failed ones.
- o_wr_code and o_wr_owner change only in IDLE on a grant.
- Counters are wide enough for TIMEOUT_CYC and MIN_GAP and are cleared on state entry.
- Reset during WAIT/GAP aborts immediately. No o_err is issued, and the engine is expected to share the same reset.

Decomposition:
- Shared package dac_pkg:
  - DAC_CODE_W=12
  - MCP4725 power-down encodings (PD_NORMAL=2'b00)
  - state encoding IDLE/ISSUE/WAIT/GAP
  - DAC_ADDR_W=8'hC2
- Sub-module rr_arbiter:
  - Combinational first-set-at-or-after-pointer over N_REQ.
  - Outputs one-hot grant plus index and any_req.
  - Pointer register lives in the scheduler.

Test Plan:
- Single request: valid[1] with code 0x7FF, engine done without NACK 10 cycles after start. Expect o_wr_start 2 cycles after valid, o_wr_code=0x7FF, o_wr_owner=1, o_done[1] pulse, next start no earlier than MIN_GAP after done.
- Round robin: valid on requesters 0,1,2,3 in the same cycle with codes 0x100..0x103. Expect starts in order 0,1,2,3, each with its own code. Repeat with ptr=2: order 2,3,0,1.
- Overwrite: while the engine is busy on requester 0, valid[1]=0x111 then valid[1]=0x222. Expect o_overwrite[1] pulse and only 0x222 written for requester 1.
- NACK retry: MAX_RETRY=2, engine returns NACK three times for code 0xABC. Expect 3 starts with 0xABC each separated by MIN_GAP, then o_err with o_err_owner=owner and no o_done.
- Timeout: TIMEOUT_CYC=100, engine never signals done. Expect o_err at cycle 100 of WAIT; a later stray i_wr_done produces no o_done.
- Grant-cycle collision and reset: valid[0] in the same cycle requester 0 is granted leaves pending[0]=1 with the new code. Asserting reset in WAIT clears o_pending, suppresses o_err, and the FSM resumes from IDLE.
